outc_alloc: RTL

OUTC_ALLOC -- requirements
Module: outc_alloc

---
 rtl/noc_pkg.sv | 27 ++
 rtl/rr_arb.sv | 27 ++
 rtl/outc_alloc.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants, flit type codes and the output allocator state type.
package noc_pkg;

  localparam int PORT_N   = 5;
  localparam int PORT_W   = $clog2(PORT_N);
  localparam int VCH_N    = 2;
  localparam int VCH_W    = 1;
  localparam int DATA_W   = 16;
  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 14;

  localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_HEAD     = 2'b00;
  localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_BODY     = 2'b01;
  localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_TAIL     = 2'b10;
  localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_HEADTAIL = 2'b11;

  typedef enum logic {
    ALLOC_IDLE = 1'b0,
    ALLOC_BUSY = 1'b1
  } alloc_state_t;

  // True for the flit types that close a packet.
  function automatic logic flit_is_last(input logic [TYPE_MSB-TYPE_LSB:0] kind);
    return (kind == TYPE_TAIL) || (kind == TYPE_HEADTAIL);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arb
  import noc_pkg::*;
(
  input  logic [PORT_N-1:0] req,
  input  logic [PORT_W-1:0] ptr,
  output logic [PORT_N-1:0] gnt
);

  logic              found;
  logic [PORT_W-1:0] idx;

  // Scan requesters starting at the pointer and grant the first one found.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < PORT_N; i++) begin
      idx = PORT_W'((int'(ptr) + i) % PORT_N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outc_alloc.sv
// Output channel allocator: grants one input packet at a time onto this
// output, forwards its flits with one cycle latency and tracks downstream
// credits per virtual channel.
module outc_alloc
  import noc_pkg::*;
#(
  parameter int ROUTERID  = 0,
  parameter int PCHID     = 0,
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_N-1:0]              req_i,
  input  logic [PORT_N-1:0][VCH_W-1:0]   vch_i,
  input  logic [PORT_N-1:0]              send_i,
  input  logic [PORT_N-1:0][DATA_W-1:0]  data_i,
  input  logic [VCH_N-1:0]               credit_i,
  output logic [PORT_N-1:0]              grt_o,
  output logic [VCH_N-1:0]               lck_o,
  output logic [VCH_N-1:0]               rdy_o,
  output logic                           valid_o,
  output logic [DATA_W-1:0]              data_o,
  output logic [VCH_W-1:0]               vch_o,
  output logic                           err_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  // Negative indices or an empty downstream buffer make no sense here.
  if (ROUTERID < 0 || PCHID < 0 || BUF_DEPTH < 1) begin : g_param_check
    $error("outc_alloc: invalid ROUTERID/PCHID/BUF_DEPTH");
  end

  alloc_state_t                  state_q, state_d;
  logic [PORT_W-1:0]             rr_ptr_q, owner_q, win_idx;
  logic [VCH_W-1:0]              owner_vc_q, vch_q;
  logic                          seen_q, valid_q, err_q;
  logic [PORT_N-1:0]             elig, arb_gnt, grt_q;
  logic [VCH_N-1:0]              lck_q, lck_new, dec;
  logic [VCH_N-1:0][CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]             flit, data_q;
  logic                          accept, last_flit, abort, grant;

  assign accept    = (state_q == ALLOC_BUSY) && send_i[owner_q];
  assign flit      = data_i[owner_q];
  assign last_flit = flit_is_last(flit[TYPE_MSB:TYPE_LSB]);
  assign abort     = (state_q == ALLOC_BUSY) && !accept && !req_i[owner_q] && !seen_q;

  // A VC is ready whenever its downstream buffer has room for a flit.
  always_comb begin
    rdy_o = '0;
    for (int v = 0; v < VCH_N; v++) begin
      rdy_o[v] = (cnt_q[v] != '0);
    end
  end

  // Only idle-state requests whose target VC has credit compete for the output.
  always_comb begin
    elig = '0;
    for (int p = 0; p < PORT_N; p++) begin
      elig[p] = (state_q == ALLOC_IDLE) && req_i[p] && rdy_o[vch_i[p]];
    end
  end

  rr_arb u_arb (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Convert the one-hot winner into a port index and its requested VC lock.
  always_comb begin
    win_idx = '0;
    for (int p = 0; p < PORT_N; p++) begin
      if (arb_gnt[p]) win_idx = PORT_W'(p);
    end
    lck_new = '0;
    lck_new[vch_i[win_idx]] = 1'b1;
  end

  // Which VC counter loses a credit to the flit accepted this cycle.
  always_comb begin
    dec = '0;
    for (int v = 0; v < VCH_N; v++) begin
      dec[v] = accept && (owner_vc_q == VCH_W'(v));
    end
  end

  // Next state: grant from idle, release on the closing flit or an early abort.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ALLOC_IDLE: begin
        if (|elig) begin
          state_d = ALLOC_BUSY;
          grant   = 1'b1;
        end
      end
      ALLOC_BUSY: begin
        if ((accept && last_flit) || abort) state_d = ALLOC_IDLE;
      end
      default: state_d = ALLOC_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ALLOC_IDLE;
    else     state_q <= state_d;
  end

  // Packet ownership, round-robin pointer and the registered grant/lock outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      owner_vc_q <= '0;
      seen_q     <= 1'b0;
      grt_q      <= '0;
      lck_q      <= '0;
    end else begin
      if (grant) begin
        owner_q    <= win_idx;
        owner_vc_q <= vch_i[win_idx];
        rr_ptr_q   <= (win_idx == PORT_W'(PORT_N - 1)) ? '0 : win_idx + PORT_W'(1);
        grt_q      <= arb_gnt;
        lck_q      <= lck_new;
        seen_q     <= 1'b0;
      end else if (state_d == ALLOC_IDLE) begin
        grt_q <= '0;
        lck_q <= '0;
      end
      if (accept) seen_q <= 1'b1;
    end
  end

  // Forward accepted flits one cycle later; data and VC hold between flits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      vch_q   <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        data_q <= flit;
        vch_q  <= owner_vc_q;
      end
    end
  end

  // Credit counters saturate at 0 and BUF_DEPTH, flagging a sticky error when they would wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VCH_N; v++) cnt_q[v] <= CNT_W'(BUF_DEPTH);
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < VCH_N; v++) begin
        if (dec[v] && !credit_i[v]) begin
          if (cnt_q[v] == '0) err_q <= 1'b1;
          else                cnt_q[v] <= cnt_q[v] - CNT_W'(1);
        end else if (credit_i[v] && !dec[v]) begin
          if (cnt_q[v] == CNT_W'(BUF_DEPTH)) err_q <= 1'b1;
          else                               cnt_q[v] <= cnt_q[v] + CNT_W'(1);
        end
      end
    end
  end

  assign grt_o   = grt_q;
  assign lck_o   = lck_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign vch_o   = vch_q;
  assign err_o   = err_q;

endmodule
